// File: rtl/i_cache_axi_rd_bridge_pkg.sv
// ---------------------------------------------------------------------------
// i_cache_axi_rd_bridge_pkg
// Shared AXI4 encodings and bridge FSM state type for the I-cache refill
// read bridge.
//   AXI_SIZE_8B / AXI_BURST_INCR  : fixed AR attributes for one 64-bit beat
//   AXI_RESP_*                    : RRESP encodings
//   bridge_state_e                : one-hot bridge FSM states
//   DWORD_ADDR_MASK               : clears byte offset within a doubleword
// ---------------------------------------------------------------------------
package i_cache_axi_rd_bridge_pkg;

  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [63:0] DWORD_ADDR_MASK = ~64'h7;

  // One-hot encoding, matching the cache FSMs.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_AR_REQ = 4'b0010,
    ST_R_WAIT = 4'b0100,
    ST_RESP   = 4'b1000
  } bridge_state_e;

endpackage

// File: rtl/i_cache_axi_rd_bridge.sv
// ---------------------------------------------------------------------------
// i_cache_axi_rd_bridge
// Memory-side responder for the I-cache refill port. Each accepted request
// becomes one single-beat 64-bit AXI4 read; the returned doubleword is
// presented on cache_in_data/cache_in_valid and held until cache_read_resp.
// One transaction outstanding at a time.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   cache_read_ena      refill request (sampled only in IDLE)
//   cache_addr[63:0]    request address, byte offset bits ignored
//   cache_read_resp     i_cache consumed the data (honoured only in RESP)
//   cache_in_data[63:0] returned doubleword (zero on any error)
//   cache_in_valid      data valid, held until cache_read_resp
//   bus_err             one-cycle pulse on bad RRESP/RID/RLAST or timeout
//   axi_ar_*            AR channel master side
//   axi_r_*             R channel master side
// ---------------------------------------------------------------------------
module i_cache_axi_rd_bridge
  import i_cache_axi_rd_bridge_pkg::*;
#(
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] AXI_ID    = '0,
  parameter int              TIMEOUT_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cache_read_ena,
  input  logic [63:0]     cache_addr,
  input  logic            cache_read_resp,
  output logic [63:0]     cache_in_data,
  output logic            cache_in_valid,
  output logic            bus_err,
  output logic            axi_ar_valid,
  input  logic            axi_ar_ready,
  output logic [63:0]     axi_ar_addr,
  output logic [ID_W-1:0] axi_ar_id,
  output logic [7:0]      axi_ar_len,
  output logic [2:0]      axi_ar_size,
  output logic [1:0]      axi_ar_burst,
  input  logic            axi_r_valid,
  output logic            axi_r_ready,
  input  logic [63:0]     axi_r_data,
  input  logic [1:0]      axi_r_resp,
  input  logic            axi_r_last,
  input  logic [ID_W-1:0] axi_r_id
);

  // The watchdog expires on the last of 2**TIMEOUT_W-1 cycles in R_WAIT,
  // i.e. when the counter (starting at 0) shows 2**TIMEOUT_W-2.
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  bridge_state_e        state;
  bridge_state_e        state_nxt;
  logic [63:0]          addr_q;
  logic [63:0]          data_q;
  logic [TIMEOUT_W-1:0] timer_q;
  logic                 bus_err_q;
  logic                 r_fire;
  logic                 r_bad;
  logic                 timeout;

  assign r_fire  = (state == ST_R_WAIT) && axi_r_valid;
  assign r_bad   = (axi_r_resp != AXI_RESP_OKAY) || (axi_r_id != AXI_ID) || !axi_r_last;
  // A beat arriving on the expiry cycle wins over the timeout.
  assign timeout = (state == ST_R_WAIT) && !axi_r_valid && (timer_q == TIMER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cache_read_ena)     state_nxt = ST_AR_REQ;
      ST_AR_REQ: if (axi_ar_ready)       state_nxt = ST_R_WAIT;
      ST_R_WAIT: if (r_fire || timeout)  state_nxt = ST_RESP;
      ST_RESP:   if (cache_read_resp)    state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      data_q    <= '0;
      timer_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      if ((state == ST_IDLE) && cache_read_ena) begin
        addr_q <= cache_addr & DWORD_ADDR_MASK;
      end
      if (state == ST_R_WAIT) begin
        timer_q <= timer_q + TIMEOUT_W'(1);
      end else begin
        timer_q <= '0;
      end
      // Faulty or missing data is replaced by zero, which decodes as an
      // illegal instruction in the core.
      if (r_fire) begin
        data_q    <= r_bad ? 64'h0 : axi_r_data;
        bus_err_q <= r_bad;
      end else if (timeout) begin
        data_q    <= 64'h0;
        bus_err_q <= 1'b1;
      end
    end
  end

  assign axi_ar_valid   = (state == ST_AR_REQ);
  assign axi_r_ready    = (state == ST_R_WAIT);
  assign cache_in_valid = (state == ST_RESP);
  assign cache_in_data  = data_q;
  assign bus_err        = bus_err_q;
  assign axi_ar_addr    = addr_q;
  assign axi_ar_id      = AXI_ID;
  assign axi_ar_len     = 8'd0;
  assign axi_ar_size    = AXI_SIZE_8B;
  assign axi_ar_burst   = AXI_BURST_INCR;

endmodule

// File: tb/tb_i_cache_axi_rd_bridge.sv
// ---------------------------------------------------------------------------
// tb_i_cache_axi_rd_bridge
// Self-checking bench for i_cache_axi_rd_bridge: a table of directed
// transactions, randomized transactions checked against a reference model,
// and hand-written reset-mid-transaction and watchdog sequences.
// ---------------------------------------------------------------------------
module tb_i_cache_axi_rd_bridge;

  localparam int         ID_W  = 4;
  localparam logic [3:0] TB_ID = 4'h5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_read_ena;
  logic [63:0] cache_addr;
  logic        cache_read_resp;
  logic [63:0] cache_in_data;
  logic        cache_in_valid;
  logic        bus_err;
  logic        axi_ar_valid;
  logic        axi_ar_ready;
  logic [63:0] axi_ar_addr;
  logic [3:0]  axi_ar_id;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [1:0]  axi_ar_burst;
  logic        axi_r_valid;
  logic        axi_r_ready;
  logic [63:0] axi_r_data;
  logic [1:0]  axi_r_resp;
  logic        axi_r_last;
  logic [3:0]  axi_r_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i_cache_axi_rd_bridge #(.ID_W(ID_W), .AXI_ID(TB_ID), .TIMEOUT_W(10)) dut (
    .clk(clk), .rst(rst),
    .cache_read_ena(cache_read_ena), .cache_addr(cache_addr),
    .cache_read_resp(cache_read_resp), .cache_in_data(cache_in_data),
    .cache_in_valid(cache_in_valid), .bus_err(bus_err),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_ar_addr(axi_ar_addr), .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len),
    .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
    .axi_r_last(axi_r_last), .axi_r_id(axi_r_id)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
    int          ar_dly;
    int          r_dly;
    int          hold;
    logic        ena_pulse;
    logic [63:0] exp_addr;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the bridge must return for one beat.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   ok;
    r = v;
    r.exp_addr = v.addr - (v.addr % 64'd8);
    ok = (v.resp == 2'b00) && (v.id == TB_ID) && v.last;
    r.exp_data = ok ? v.data : 64'h0;
    r.exp_err  = !ok;
    return r;
  endfunction

  // Drives one complete transaction, all inputs changed and outputs checked
  // on the falling edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    cache_read_ena = 1'b1;
    cache_addr     = v.addr;
    @(negedge clk);
    cache_read_ena = 1'b0;
    cache_addr     = ~v.addr;
    chk("ar_valid_first", {63'd0, axi_ar_valid}, 64'd1);
    chk("ar_addr", axi_ar_addr, v.exp_addr);
    chk("ar_id", {60'd0, axi_ar_id}, {60'd0, TB_ID});
    chk("ar_len_size_burst", {51'd0, axi_ar_len, axi_ar_size, axi_ar_burst}, {51'd0, 8'd0, 3'b011, 2'b01});
    for (int i = 0; i < v.ar_dly; i++) begin
      axi_ar_ready = 1'b0;
      @(negedge clk);
      chk("ar_valid_hold", {63'd0, axi_ar_valid}, 64'd1);
      chk("ar_addr_hold", axi_ar_addr, v.exp_addr);
    end
    axi_ar_ready = 1'b1;
    @(negedge clk);
    axi_ar_ready = 1'b0;
    chk("ar_valid_drop", {63'd0, axi_ar_valid}, 64'd0);
    chk("r_ready", {63'd0, axi_r_ready}, 64'd1);
    for (int i = 0; i < v.r_dly; i++) begin
      @(negedge clk);
      chk("r_wait_state", {61'd0, axi_r_ready, cache_in_valid, bus_err}, {61'd0, 3'b100});
    end
    axi_r_valid = 1'b1;
    axi_r_data  = v.data;
    axi_r_resp  = v.resp;
    axi_r_id    = v.id;
    axi_r_last  = v.last;
    @(negedge clk);
    axi_r_valid = 1'b0;
    axi_r_data  = {$urandom, $urandom};
    chk("valid_rise", {62'd0, cache_in_valid, axi_r_ready}, {62'd0, 2'b10});
    chk("data", cache_in_data, v.exp_data);
    chk("bus_err_pulse", {63'd0, bus_err}, {63'd0, v.exp_err});
    for (int i = 0; i < v.hold; i++) begin
      cache_read_ena = v.ena_pulse & ~i[0];
      @(negedge clk);
      chk("hold_ctl", {61'd0, cache_in_valid, bus_err, axi_ar_valid}, {61'd0, 3'b100});
      chk("hold_data", cache_in_data, v.exp_data);
    end
    cache_read_ena  = 1'b0;
    cache_read_resp = 1'b1;
    @(negedge clk);
    cache_read_resp = 1'b0;
    chk("released", {61'd0, cache_in_valid, bus_err, axi_ar_valid}, {61'd0, 3'b000});
  endtask

  vec_t tbl [7];
  vec_t v;
  int   cnt;

  initial begin
    rst = 1'b1;
    cache_read_ena = 0; cache_addr = 0; cache_read_resp = 0;
    axi_ar_ready = 0; axi_r_valid = 0; axi_r_data = 0;
    axi_r_resp = 0; axi_r_last = 0; axi_r_id = 0;

    //        addr                   data                   resp   id     last ar r  hold pulse exp_addr               exp_data               err
    tbl[0] = '{64'h8000_0014, 64'h0013_0000_0093_0000, 2'b00, TB_ID, 1'b1, 0, 0, 0, 1'b0, 64'h8000_0010, 64'h0013_0000_0093_0000, 1'b0};
    tbl[1] = '{64'h1234_5678_9ABC_DEF7, 64'hCAFE_F00D_0BAD_1DEA, 2'b00, TB_ID, 1'b1, 5, 7, 1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'hCAFE_F00D_0BAD_1DEA, 1'b0};
    tbl[2] = '{64'h0000_0000_0000_1008, 64'h0000_0000_DEAD_BEEF, 2'b10, TB_ID, 1'b1, 0, 1, 2, 1'b0, 64'h0000_0000_0000_1008, 64'h0,                  1'b1};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444, 2'b00, TB_ID, 1'b1, 1, 0, 4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1111_2222_3333_4444, 1'b0};
    tbl[4] = '{64'h0000_0000_0000_0020, 64'h5555_6666_7777_8888, 2'b00, 4'h3,  1'b1, 0, 0, 0, 1'b0, 64'h0000_0000_0000_0020, 64'h0,                  1'b1};
    tbl[5] = '{64'h0000_0000_0000_0031, 64'h9999_AAAA_BBBB_CCCC, 2'b00, TB_ID, 1'b0, 0, 2, 0, 1'b0, 64'h0000_0000_0000_0030, 64'h0,                  1'b1};
    tbl[6] = '{64'h0000_0000_4000_0046, 64'hABCD_EF01_2345_6789, 2'b00, TB_ID, 1'b1, 2, 0, 0, 1'b0, 64'h0000_0000_4000_0040, 64'hABCD_EF01_2345_6789, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_ctl", {60'd0, axi_ar_valid, axi_r_ready, cache_in_valid, bus_err}, 64'd0);
    chk("reset_data", cache_in_data, 64'h0);
    chk("reset_addr", axi_ar_addr, 64'h0);
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset while waiting for R; cache_in_data still holds the last table data.
    @(negedge clk);
    cache_read_ena = 1'b1; cache_addr = 64'h7000_0000;
    @(negedge clk);
    cache_read_ena = 1'b0; axi_ar_ready = 1'b1;
    @(negedge clk);
    axi_ar_ready = 1'b0;
    chk("pre_reset_r_wait", {63'd0, axi_r_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset_ctl", {60'd0, axi_ar_valid, axi_r_ready, cache_in_valid, bus_err}, 64'd0);
    chk("async_reset_data", cache_in_data, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(tbl[0]);

    // Watchdog: R never arrives.
    @(negedge clk);
    cache_read_ena = 1'b1; cache_addr = 64'h8000_0100;
    @(negedge clk);
    cache_read_ena = 1'b0; axi_ar_ready = 1'b1;
    @(negedge clk);
    axi_ar_ready = 1'b0;
    cnt = 0;
    while (axi_r_ready && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_cycles", 64'(cnt), 64'd1023);
    chk("timeout_ctl", {62'd0, cache_in_valid, bus_err}, {62'd0, 2'b11});
    chk("timeout_data", cache_in_data, 64'h0);
    @(negedge clk);
    chk("timeout_err_one_cycle", {62'd0, cache_in_valid, bus_err}, {62'd0, 2'b10});
    cache_read_resp = 1'b1;
    @(negedge clk);
    cache_read_resp = 1'b0;
    chk("timeout_release", {63'd0, cache_in_valid}, 64'd0);

    // Randomized transactions against the reference model.
    for (int k = 0; k < 40; k++) begin
      v.addr      = {$urandom, $urandom};
      v.data      = {$urandom, $urandom};
      v.resp      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.id        = ($urandom_range(0, 7) == 0) ? TB_ID ^ 4'($urandom_range(1, 15)) : TB_ID;
      v.last      = ($urandom_range(0, 7) != 0);
      v.ar_dly    = $urandom_range(0, 3);
      v.r_dly     = $urandom_range(0, 3);
      v.hold      = $urandom_range(0, 3);
      v.ena_pulse = 1'($urandom_range(0, 1));
      run_vec(model(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
